// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential reverse double-dabble BCD-to-binary converter, one bit per clock.
// Define BCD_DIGIT_CHECK_EN to reject inputs containing digits above 9 (sets error, skips SHIFT).
module bcd_to_binary #(
   parameter int N      = 20,
   parameter int DIGITS = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [N-1:0]          binary,
   output logic                  error
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state, state_nx;
   logic [BW-1:0] bcd_reg, bcd_sh;
   logic [N-1:0] bin_reg, bin_sh;
   logic [CW-1:0] cnt;
   logic last, bad, accept;
   assign ready  = state == IDLE;
   assign busy   = state == SHIFT;
   assign done   = state == DONE;
   assign last   = cnt == CW'(N - 1);
   assign accept = ready && start;
   // a digit >= 8 has its MSB set; subtracting 3 undoes the +3 the forward algorithm applied
   always_comb begin
      bcd_sh = {1'b0, bcd_reg[BW-1:1]};
      bin_sh = {bcd_reg[0], bin_reg[N-1:1]};
      for (int i = 0; i < DIGITS; i++)
         if (bcd_sh[4*i+3]) bcd_sh[4*i+:4] = bcd_sh[4*i+:4] - 4'd3;
   end
`ifdef BCD_DIGIT_CHECK_EN
   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) bad = bad | (bcd_in[4*i+:4] > 4'd9);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) error <= 1'b0;
      else if (accept) error <= bad;
`else
   assign bad   = 1'b0;
   assign error = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = IDLE;
      state_nx = state == IDLE  ? (start ? (bad ? DONE : SHIFT) : IDLE) :
                 state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bcd_reg <= '0;
         bin_reg <= '0;
         cnt     <= '0;
         binary  <= '0;
      end else if (accept) begin
         bcd_reg <= bcd_in;
         bin_reg <= '0;
         cnt     <= '0;
         if (bad) binary <= '0;
      end else if (busy) begin
         bcd_reg <= bcd_sh;
         bin_reg <= bin_sh;
         cnt     <= cnt + 1'b1;
         if (last) binary <= bin_sh;
      end
endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: directed vectors, cycle-level timing model and literal checks for bcd_to_binary.
module tb_bcd_to_binary;
   localparam int N = 20;
   localparam int DIGITS = 6;
`ifdef BCD_DIGIT_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [23:0] bcd_in = '0;
   logic ready, busy, done, error;
   logic [N-1:0] binary;
   int errors = 0, checks = 0, cyc = 0;

   bcd_to_binary #(.N(N), .DIGITS(DIGITS)) dut (
      .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
      .ready(ready), .busy(busy), .done(done), .binary(binary), .error(error));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int unsigned bcd_val(input logic [23:0] b);
      int unsigned v = 0, p = 1;
      for (int k = 0; k < DIGITS; k++) begin
         v += int'(b[4*k+:4]) * p;
         p *= 10;
      end
      return v;
   endfunction

   function automatic bit bcd_bad(input logic [23:0] b);
      for (int k = 0; k < DIGITS; k++) if (b[4*k+:4] > 4'd9) return 1'b1;
      return 1'b0;
   endfunction

   // model: phase -1 idle, 0..N-1 converting, N done cycle
   int m_phase = -1;
   int unsigned m_val = 0, m_bin = 0;
   bit m_err = 0, m_binx = 0, m_badv = 0;
   always @(posedge clk or posedge rst)
      if (rst) begin
         m_phase = -1; m_bin = 0; m_err = 0; m_binx = 0;
      end else if (m_phase == -1) begin
         if (start) begin
            m_val = bcd_val(bcd_in);
            m_badv = bcd_bad(bcd_in);
            if (m_badv && CHK) begin
               m_phase = N; m_bin = 0; m_err = 1; m_binx = 0;
            end else begin
               m_phase = 0; m_err = 0;
            end
         end
      end else if (m_phase < N - 1) m_phase++;
      else if (m_phase == N - 1) begin
         m_phase = N; m_bin = m_val; m_binx = m_badv;
      end else m_phase = -1;

   always @(negedge clk)
      if (!rst) begin
         chk("ready", 32'(ready), 32'(m_phase == -1));
         chk("busy", 32'(busy), 32'(m_phase >= 0 && m_phase < N));
         chk("done", 32'(done), 32'(m_phase == N));
         chk("error", 32'(error), 32'(m_err));
         if (!m_binx) chk("binary", 32'(binary), m_bin);
      end

   task automatic wait_done(output int lat, output int bsy);
      lat = -1;
      bsy = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         bsy += int'(busy);
         if (done) begin
            lat = i;
            return;
         end
      end
   endtask

   task automatic convert(input logic [23:0] v, output int lat, output int bsy);
      @(negedge clk);
      bcd_in = v;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(lat, bsy);
   endtask

   int lat, bsy, t_prev;
   logic [23:0] hv [3] = '{24'h000314, 24'h500005, 24'h089012};
   logic [31:0] he [3] = '{32'd314, 32'd500005, 32'd89012};

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_binary", 32'(binary), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      rst = 1'b0;
      convert(24'h000000, lat, bsy);
      chk("zero_lat", lat, N + 1);
      chk("zero_busy", bsy, N);
      chk("zero_bin", 32'(binary), 32'd0);
      convert(24'h999999, lat, bsy);
      chk("nines_lat", lat, N + 1);
      chk("nines_bin", 32'(binary), 32'hF423F);
      convert(24'h123456, lat, bsy);
      chk("seq_lat", lat, N + 1);
      chk("seq_bin", 32'(binary), 32'h1E240);
      // start held high: back-to-back conversions, input scrambled during SHIFT
      start = 1'b1;
      t_prev = 0;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 60 && !ready; i++) @(negedge clk);
         bcd_in = hv[k];
         @(negedge clk);
         bcd_in = 24'h987654;
         wait_done(lat, bsy);
         chk("held_bin", 32'(binary), he[k]);
         if (k > 0) chk("held_spacing", cyc - t_prev, N + 2);
         t_prev = cyc;
      end
      start = 1'b0;
      @(negedge clk);
      // reset in the middle of a conversion
      @(negedge clk);
      bcd_in = 24'h777777;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_ready", 32'(ready), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_binary", 32'(binary), 32'd0);
      chk("mid_rst_error", 32'(error), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      convert(24'h000001, lat, bsy);
      chk("after_rst_lat", lat, N + 1);
      chk("after_rst_bin", 32'(binary), 32'd1);
      // invalid digit
      convert(24'h12A456, lat, bsy);
      if (CHK) begin
         chk("bad_lat", lat, 1);
         chk("bad_err", 32'(error), 32'd1);
         chk("bad_bin", 32'(binary), 32'd0);
      end else begin
         chk("bad_lat", lat, N + 1);
         chk("bad_err", 32'(error), 32'd0);
      end
      convert(24'h000042, lat, bsy);
      chk("after_bad_lat", lat, N + 1);
      chk("after_bad_err", 32'(error), 32'd0);
      chk("after_bad_bin", 32'(binary), 32'h2A);
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
